// File: rtl/fft_bitrev_serializer.sv
// Ping-pong frame buffer: takes a 16-point bit-reversed FFT frame in parallel
// and streams it out one complex bin per beat in natural order.
module fft_bitrev_serializer #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_data0,
  input  logic [2*W-1:0] in_data1,
  input  logic [2*W-1:0] in_data2,
  input  logic [2*W-1:0] in_data3,
  input  logic [2*W-1:0] in_data4,
  input  logic [2*W-1:0] in_data5,
  input  logic [2*W-1:0] in_data6,
  input  logic [2*W-1:0] in_data7,
  input  logic [2*W-1:0] in_data8,
  input  logic [2*W-1:0] in_data9,
  input  logic [2*W-1:0] in_data10,
  input  logic [2*W-1:0] in_data11,
  input  logic [2*W-1:0] in_data12,
  input  logic [2*W-1:0] in_data13,
  input  logic [2*W-1:0] in_data14,
  input  logic [2*W-1:0] in_data15,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_real,
  output logic [W-1:0]   out_imag,
  output logic [3:0]     out_index,
  output logic           out_last,
  output logic           busy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_t;

  bank_state_t    st [2];
  bank_state_t    st_nxt [2];
  logic           wr_bank, wr_bank_nxt;
  logic           rd_bank, rd_bank_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic [2*W-1:0] mem [2][16];
  logic [2*W-1:0] in_words [16];
  logic [2*W-1:0] rd_word;
  logic           frame_acc;
  logic           beat_acc;

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  function automatic logic signed [W-1:0] word_real(input logic [2*W-1:0] w);
    return w[2*W-1:W];
  endfunction

  function automatic logic signed [W-1:0] word_imag(input logic [2*W-1:0] w);
    return w[W-1:0];
  endfunction

  assign in_words[0]  = in_data0;
  assign in_words[1]  = in_data1;
  assign in_words[2]  = in_data2;
  assign in_words[3]  = in_data3;
  assign in_words[4]  = in_data4;
  assign in_words[5]  = in_data5;
  assign in_words[6]  = in_data6;
  assign in_words[7]  = in_data7;
  assign in_words[8]  = in_data8;
  assign in_words[9]  = in_data9;
  assign in_words[10] = in_data10;
  assign in_words[11] = in_data11;
  assign in_words[12] = in_data12;
  assign in_words[13] = in_data13;
  assign in_words[14] = in_data14;
  assign in_words[15] = in_data15;

  // Handshakes are gated only by registered bank state, so no input reaches an output.
  assign in_ready  = (st[wr_bank] == EMPTY);
  assign out_valid = (st[rd_bank] == FULL);
  assign frame_acc = in_valid && in_ready;
  assign beat_acc  = out_valid && out_ready;

  assign rd_word   = mem[rd_bank][bitrev4(cnt)];
  assign out_real  = word_real(rd_word);
  assign out_imag  = word_imag(rd_word);
  assign out_index = cnt;
  assign out_last  = out_valid && (cnt == 4'd15);
  assign busy      = (st[0] == FULL) || (st[1] == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < 16; s++) begin
          mem[b][s] <= '0;
        end
      end
    end else if (frame_acc) begin
      for (int s = 0; s < 16; s++) begin
        mem[wr_bank][s] <= in_words[s];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st[0]   <= EMPTY;
      st[1]   <= EMPTY;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      cnt     <= 4'd0;
    end else begin
      st[0]   <= st_nxt[0];
      st[1]   <= st_nxt[1];
      wr_bank <= wr_bank_nxt;
      rd_bank <= rd_bank_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // A frame write and a final-beat drain always touch different banks.
  always_comb begin
    st_nxt[0]   = st[0];
    st_nxt[1]   = st[1];
    wr_bank_nxt = wr_bank;
    rd_bank_nxt = rd_bank;
    cnt_nxt     = cnt;
    if (frame_acc) begin
      st_nxt[wr_bank] = FULL;
      wr_bank_nxt     = ~wr_bank;
    end
    if (beat_acc) begin
      if (cnt == 4'd15) begin
        cnt_nxt         = 4'd0;
        st_nxt[rd_bank] = EMPTY;
        rd_bank_nxt     = ~rd_bank;
      end else begin
        cnt_nxt = cnt + 4'd1;
      end
    end
  end

endmodule

// File: doc/fft_bitrev_serializer.md
# fft_bitrev_serializer

Output-side companion to the parallel FFT butterfly stages. Accepts one 16-point frame per handshake, as 16 parallel 32-bit words in {real[31:16], imag[15:0]} format and bit-reversed order. Buffers the frame in a two-bank (ping-pong) store. Streams the frame out one complex sample per beat, in natural frequency order, over a valid/ready interface. Sits between the last FFT stage and the result writer, decoupling the wide combinational datapath from the serial consumer.

## Interface
- W, 16, width of each real/imag component; word width is 2*W. No other value is supported.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  frame on in_data0..in_data15 is valid
- in_ready  out  1  block can accept a frame this cycle
- in_data0 .. in_data15  in  32 each  FFT outputs in bit-reversed slot order, {real, imag}, signed two's complement
- out_valid  out  1  out_real/out_imag/out_index valid
- out_ready  in  1  consumer accepts the beat this cycle
- out_real  out  16  real part of current bin
- out_imag  out  16  imaginary part of current bin
- out_index  out  4  natural-order bin number 0..15
- out_last  out  1  high with out_valid on bin 15
- busy  out  1  either bank holds an undrained frame

## Operation
- State: two banks of 16×32-bit registers, full[1:0], wr_bank, rd_bank, 4-bit beat counter cnt.
- in_ready = ~full[wr_bank]. It is a pure function of registers and never depends on in_valid.
- Frame accept when in_valid && in_ready:
  - all 16 words are copied into bank wr_bank;
  - full[wr_bank] is set;
  - wr_bank toggles.
- out_valid = full[rd_bank].
- Output mapping: out_real/out_imag = bank[rd_bank][bitrev4(cnt)], split [31:16]/[15:0]; out_index = cnt.
  - bitrev4 maps b3b2b1b0 to b0b1b2b3, e.g. cnt=1 reads slot 8, cnt=3 reads slot 12.
- Beat accept when out_valid && out_ready:
  - if cnt<15, cnt increments;
  - if cnt==15, cnt clears to 0, full[rd_bank] clears and rd_bank toggles.
- out_last = out_valid && (cnt==15).
- busy = |full.
- Data is passed through bit-exact: no scaling, rounding or sign change.
- States per bank: EMPTY → FULL on frame accept; FULL → EMPTY on accept of its 16th beat.

## Timing
- Reset (async assert) sets:
  - full=0, wr_bank=0, rd_bank=0, cnt=0, all bank registers 0;
  - hence out_valid=0, out_last=0, busy=0, out_real=out_imag=0, out_index=0, in_ready=1.
- Reset asserted mid-frame discards both banks. No residual beats appear after release.
- Latency: a frame accepted at edge k presents bin 0 with out_valid=1 in the cycle after edge k.
- Throughput: 1 beat/cycle while out_ready=1. Frame-to-frame output is gapless when the next bank is already full.
- Backpressure: while out_valid && !out_ready, out_real/out_imag/out_index/out_last hold stable.
- No combinational path exists from any input port to any output port. in_ready, out_valid and data all derive from registers.
- Simultaneous frame accept (into wr_bank) and final-beat accept (from rd_bank) in one cycle is legal; the two always refer to different banks.
- in_ready rises in the cycle after the 16th beat of the draining bank is accepted.
- in_valid while in_ready=0 is ignored; the producer holds data until accepted.

## Test plan
- Reset: pulse rst for 2 cycles with random inputs → after release in_ready=1, out_valid=0, busy=0, out_real=out_imag=0.
- Single frame: in_data[k]={16'(k), 16'(16'h0100+k)}, out_ready=1 → 16 beats, out_index 0..15, out_real sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, out_imag = 16'h0100+out_real, out_last only on beat 16, then busy=0.
- Backpressure: same frame, drop out_ready for 5 cycles at out_index=3 → out_real=12 held for all 5 cycles; sequence resumes with no skipped or duplicated bins.
- Back-to-back: offer frames A, B, C continuously, out_ready=1:
  - A and B are accepted on consecutive edges;
  - in_ready then stays 0 until A's 16th beat is accepted;
  - C is accepted the next cycle;
  - output is 48 gapless beats in order A, B, C.
- Reset mid-stream: assert rst after beat 7 of a frame with a second frame queued → out_valid falls immediately; after release no beats are emitted until a new frame is accepted.
- Sign extremes: slot 0 = 32'h8000_7FFF, slot 15 = 32'h7FFF_8000 → out_index 0 gives real 16'h8000/imag 16'h7FFF; out_index 15 gives real 16'h7FFF/imag 16'h8000, bit-exact.
